// File: rtl/png_chunk_ctrl.sv
// PNG chunk sequencer: streams length, type, data and CRC words while pacing data into crc32_core.
// Define PNG_CHUNK_LEN_CHK_EN to enable the sticky length-mismatch flag on err_o (otherwise tied 0).
module png_chunk_ctrl #(
  parameter int PACE_CYC = 4,
  parameter int LEN_WD   = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start_i,
  input  logic [31:0] len_i,
  input  logic [31:0] type_i,
  input  logic        val_i,
  input  logic [31:0] dat_i,
  input  logic [1:0]  num_i,
  input  logic        lst_i,
  output logic        rdy_o,
  output logic        crc_start_o,
  output logic        crc_val_o,
  output logic [31:0] crc_dat_o,
  output logic [1:0]  crc_num_o,
  output logic        crc_lst_o,
  input  logic        crc_done_i,
  input  logic [31:0] crc_dat_i,
  output logic        val_o,
  output logic [31:0] dat_o,
  output logic [1:0]  num_o,
  output logic        lst_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int            PW        = (PACE_CYC > 1) ? $clog2(PACE_CYC) : 1;
  localparam logic [PW-1:0] PACE_LAST = PW'(PACE_CYC - 1);
  localparam logic [PW-1:0] PACE_ONE  = (PACE_CYC > 1) ? PW'(1) : PW'(0);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_TYPE, S_DATA, S_WAIT, S_CRC} state_t;

  state_t            r_state;
  logic [LEN_WD-1:0] r_rem;
  logic [31:0]       r_type;
  logic [31:0]       r_crc;
  logic [PW-1:0]     r_pace;
  logic              r_val;
  logic [31:0]       r_dat;
  logic [1:0]        r_num;
  logic              r_lst;
  logic              r_done;

  logic              w_rdy;
  logic              w_xfer;
  logic              w_last;
  logic [LEN_WD-1:0] w_step;

  assign w_rdy  = (r_state == S_DATA) && (r_pace == '0);
  assign w_xfer = w_rdy && val_i;
  assign w_step = LEN_WD'(num_i) + LEN_WD'(1);
  assign w_last = (r_rem <= w_step);

  assign rdy_o       = w_rdy;
  assign crc_start_o = (r_state == S_LEN);
  assign crc_val_o   = (r_state == S_TYPE) || w_xfer;

  always_comb begin
    crc_dat_o = '0;
    crc_num_o = '0;
    crc_lst_o = 1'b0;
    case (r_state)
      S_TYPE: begin
        crc_dat_o = r_type;
        crc_num_o = 2'd3;
        crc_lst_o = (r_rem == '0);
      end
      S_DATA: begin
        crc_dat_o = dat_i;
        crc_num_o = num_i;
        crc_lst_o = w_xfer && w_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_type  <= '0;
      r_crc   <= '0;
      r_pace  <= '0;
      r_val   <= 1'b0;
      r_dat   <= '0;
      r_num   <= '0;
      r_lst   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_val  <= 1'b0;
      r_lst  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_rem   <= LEN_WD'(len_i);
            r_type  <= type_i;
            r_state <= S_LEN;
          end
        end
        S_LEN: begin
          r_val   <= 1'b1;
          r_dat   <= 32'(r_rem);
          r_num   <= 2'd3;
          r_state <= S_TYPE;
        end
        S_TYPE: begin
          r_val   <= 1'b1;
          r_dat   <= r_type;
          r_num   <= 2'd3;
          // The type word occupies pace slot 0, so the first data word waits a full engine period.
          r_pace  <= PACE_ONE;
          r_state <= (r_rem == '0) ? S_WAIT : S_DATA;
        end
        S_DATA: begin
          if (w_xfer) begin
            r_val  <= 1'b1;
            r_dat  <= dat_i;
            r_num  <= num_i;
            r_rem  <= w_last ? '0 : (r_rem - w_step);
            r_pace <= PACE_ONE;
            if (w_last) r_state <= S_WAIT;
          end else if (r_pace != '0) begin
            r_pace <= (r_pace == PACE_LAST) ? '0 : (r_pace + PW'(1));
          end
        end
        S_WAIT: begin
          if (crc_done_i) begin
            r_crc   <= crc_dat_i;
            r_state <= S_CRC;
          end
        end
        S_CRC: begin
          r_val   <= 1'b1;
          r_dat   <= r_crc;
          r_num   <= 2'd3;
          r_lst   <= 1'b1;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign val_o  = r_val;
  assign dat_o  = r_dat;
  assign num_o  = r_num;
  assign lst_o  = r_lst;
  assign done_o = r_done;

`ifdef PNG_CHUNK_LEN_CHK_EN
  logic r_err;

  // Sticky until the next accepted start; the chunk itself always follows the computed last flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err <= 1'b0;
    end else if ((r_state == S_IDLE) && start_i) begin
      r_err <= 1'b0;
    end else if (w_xfer && ((lst_i != w_last) || (w_step > r_rem))) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  logic w_unused_lst;
  assign w_unused_lst = lst_i;
  assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_png_chunk_ctrl.sv
// Self-checking bench for png_chunk_ctrl with a behavioural crc32_core model and a chunk-level reference.
module tb_png_chunk_ctrl;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] len_i = '0;
  logic [31:0] type_i = '0;
  logic        val_i = 1'b0;
  logic [31:0] dat_i = '0;
  logic [1:0]  num_i = '0;
  logic        lst_i = 1'b0;
  logic        rdy_o, crc_start_o, crc_val_o, crc_lst_o;
  logic [31:0] crc_dat_o;
  logic [1:0]  crc_num_o;
  logic        crc_done_i;
  logic [31:0] crc_dat_i;
  logic        val_o, lst_o, done_o, err_o;
  logic [31:0] dat_o;
  logic [1:0]  num_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  png_chunk_ctrl dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .len_i(len_i), .type_i(type_i),
    .val_i(val_i), .dat_i(dat_i), .num_i(num_i), .lst_i(lst_i), .rdy_o(rdy_o),
    .crc_start_o(crc_start_o), .crc_val_o(crc_val_o), .crc_dat_o(crc_dat_o),
    .crc_num_o(crc_num_o), .crc_lst_o(crc_lst_o), .crc_done_i(crc_done_i),
    .crc_dat_i(crc_dat_i), .val_o(val_o), .dat_o(dat_o), .num_o(num_o),
    .lst_o(lst_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] crc_word(input logic [31:0] c, input logic [31:0] w, input logic [1:0] n);
    logic [31:0] r;
    r = c;
    for (int i = 0; i <= int'(n); i++) r = crc_step(r, w[31-8*i -: 8]);
    return r;
  endfunction

  // crc32_core model: ACTV accepts one word, then three processing cycles; done in the third if last.
  int          eng_st = 0;
  logic        eng_lst = 1'b0;
  logic [31:0] eng_crc = 32'hFFFFFFFF;
  int          eng_viol = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      eng_st  <= 0;
      eng_lst <= 1'b0;
      eng_crc <= 32'hFFFFFFFF;
    end else begin
      if (crc_val_o && eng_st != 1) eng_viol <= eng_viol + 1;
      case (eng_st)
        0: if (crc_start_o) begin eng_st <= 1; eng_crc <= 32'hFFFFFFFF; end
        1: if (crc_val_o) begin
             eng_st  <= 2;
             eng_lst <= crc_lst_o;
             eng_crc <= crc_word(eng_crc, crc_dat_o, crc_num_o);
           end
        2: eng_st <= 3;
        3: eng_st <= 4;
        4: eng_st <= eng_lst ? 0 : 1;
        default: eng_st <= 0;
      endcase
    end
  end

  assign crc_done_i = (eng_st == 4) && eng_lst;
  assign crc_dat_i  = crc_done_i ? ~eng_crc : 32'h0;

  typedef struct packed {
    logic [31:0] dat;
    logic [1:0]  num;
    logic        lst;
    logic        done;
  } ow_t;

  ow_t oq[$];
  int  oc[$];
  int  xq[$];
  logic [7:0] db[$];

  always @(negedge clk) begin
    if (val_o) begin
      oq.push_back({dat_o, num_o, lst_o, done_o});
      oc.push_back(cyc);
    end
    if (val_i && rdy_o) xq.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    failures++;
    $display("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic set_ihdr();
    db = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01,
           8'h08, 8'h02, 8'h00, 8'h00, 8'h00};
  endtask

  // mode 0: val_i held high; 1: random val_i; 2: 10 idle cycles after word 1; 3: start pulse during DATA
  task automatic run_chunk(input logic [31:0] typ, input int mode, input logic bad_lst,
                           input logic [31:0] kcrc, input logic kchk);
    int          len;
    int          nw;
    int          s;
    int          g;
    logic [31:0] w[$];
    logic [1:0]  n[$];
    logic [7:0]  all[$];
    ow_t         exp[$];
    logic [31:0] rc;
    len = db.size();
    nw  = (len + 3) / 4;
    oq.delete(); oc.delete(); xq.delete();
    for (int i = 0; i < nw; i++) begin
      logic [31:0] wd;
      int nb;
      wd = '0;
      nb = (len - 4*i >= 4) ? 4 : len - 4*i;
      for (int b = 0; b < nb; b++) wd[31-8*b -: 8] = db[4*i+b];
      w.push_back(wd);
      n.push_back(2'(nb - 1));
    end
    for (int b = 0; b < 4; b++) all.push_back(typ[31-8*b -: 8]);
    foreach (db[i]) all.push_back(db[i]);
    rc = 32'hFFFFFFFF;
    foreach (all[i]) rc = crc_step(rc, all[i]);
    rc = ~rc;
    exp.push_back({32'(len), 2'd3, 1'b0, 1'b0});
    exp.push_back({typ, 2'd3, 1'b0, 1'b0});
    for (int i = 0; i < nw; i++) exp.push_back({w[i], n[i], 1'b0, 1'b0});
    exp.push_back({rc, 2'd3, 1'b1, 1'b1});

    start_i = 1'b1; len_i = 32'(len); type_i = typ; s = cyc;
    tick();
    start_i = 1'b0; len_i = $urandom; type_i = $urandom;

    for (int i = 0; i < nw; i++) begin
      logic xf;
      xf = 1'b0;
      g  = 0;
      while (!xf) begin
        dat_i = w[i]; num_i = n[i];
        lst_i = (i == nw - 1) || (bad_lst && i == 0);
        val_i = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
        xf = val_i && rdy_o;
        tick();
        g++;
        if (g > 200) begin timeout("xfer_wait"); val_i = 1'b0; return; end
      end
      if (mode == 2 && i == 1) begin
        val_i = 1'b0;
        for (int k = 1; k <= 10; k++) begin
          if (k >= 4) chk($sformatf("idle_rdy%0d", k), rdy_o, 1);
          tick();
        end
      end
      if (mode == 3 && i == 0) begin
        val_i = 1'b0; start_i = 1'b1; len_i = 32'd99; type_i = 32'h12345678;
        tick();
        start_i = 1'b0;
      end
    end
    val_i = 1'b0; lst_i = 1'b0;

    g = 0;
    while (!(oq.size() > 0 && oq[oq.size()-1].done) && g < 60) begin tick(); g++; end
    if (g >= 60) begin timeout("done_wait"); return; end
    tick();

    chk("nwords", oq.size(), exp.size());
    if (oq.size() == exp.size()) begin
      foreach (exp[i]) chk($sformatf("word%0d", i), oq[i], exp[i]);
      chk("len_lat", oc[0] - s, 2);
      if (len == 0) chk("crc_lat", oc[oc.size()-1] - s, 7);
      if (kchk) chk("known_crc", oq[oq.size()-1].dat, kcrc);
      chk("nxfer", xq.size(), nw);
      if (xq.size() == nw) begin
        for (int i = 0; i < nw; i++) begin
          chk($sformatf("dlat%0d", i), oc[2+i] - xq[i], 1);
          if (i == 0 && mode == 0) chk("first_xfer", xq[0] - s, 6);
          if (i > 0 && mode == 0) chk($sformatf("space%0d", i), xq[i] - xq[i-1], 4);
          if (i > 0 && mode != 0) chk($sformatf("space_min%0d", i), (xq[i] - xq[i-1]) >= 4, 1);
        end
      end
    end
    chk("eng_viol", eng_viol, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    rstn = 1'b0;
    tick(); tick();
    chk("rst_val_o", val_o, 0);
    chk("rst_dat_o", dat_o, 0);
    chk("rst_rdy_o", rdy_o, 0);
    chk("rst_crc_start", crc_start_o, 0);
    chk("rst_done_err", {done_o, lst_o, err_o, crc_val_o}, 0);
    rstn = 1'b1;
    tick();

    db.delete();
    run_chunk(32'h49454E44, 0, 1'b0, 32'hAE426082, 1'b1);
    set_ihdr();
    run_chunk(32'h49484452, 0, 1'b0, 32'h907753DE, 1'b1);
    set_ihdr();
    run_chunk(32'h49484452, 2, 1'b0, 32'h907753DE, 1'b1);
    set_ihdr();
    run_chunk(32'h49484452, 3, 1'b0, 32'h907753DE, 1'b1);

    // Reset in the middle of DATA
    start_i = 1'b1; len_i = 32'd13; type_i = 32'h49484452;
    tick();
    start_i = 1'b0; val_i = 1'b1; dat_i = 32'h1; num_i = 2'd3; lst_i = 1'b0;
    g = 0;
    while (!rdy_o && g < 20) begin tick(); g++; end
    if (g >= 20) timeout("rst_rdy_wait");
    tick();
    val_i = 1'b0;
    #1 rstn = 1'b0;
    #1;
    chk("mid_rst_val_o", val_o, 0);
    chk("mid_rst_dat_o", dat_o, 0);
    chk("mid_rst_rdy_crc", {rdy_o, crc_start_o, crc_val_o, crc_lst_o}, 0);
    chk("mid_rst_lst_done", {lst_o, done_o, err_o}, 0);
    tick();
    rstn = 1'b1;
    tick();
    chk("post_rst_idle", {rdy_o, val_o, crc_start_o}, 0);
    db.delete();
    run_chunk(32'h49454E44, 0, 1'b0, 32'hAE426082, 1'b1);

    // Wrong lst_i on the first word of an 8-byte chunk
    db.delete();
    for (int i = 0; i < 8; i++) db.push_back(8'($urandom));
    run_chunk(32'h74455874, 0, 1'b1, 32'h0, 1'b0);
`ifdef PNG_CHUNK_LEN_CHK_EN
    chk("err_set", err_o, 1);
`else
    chk("err_tied", err_o, 0);
`endif
    db.delete();
    run_chunk(32'h49454E44, 0, 1'b0, 32'hAE426082, 1'b1);
    chk("err_clr", err_o, 0);

    for (int r = 0; r < 6; r++) begin
      int len;
      len = $urandom_range(0, 22);
      db.delete();
      for (int i = 0; i < len; i++) db.push_back(8'($urandom));
      run_chunk($urandom, 1, 1'b0, 32'h0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
